// File: rtl/restoring_divider_n.sv
// Parametrised restoring divider, one quotient bit per cycle.
// Handles unsigned or truncating signed division with a divide-by-zero flag.
module restoring_divider_n #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dd_q, dd_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic             sm_q, sm_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             sgn;
  logic             dd_neg;
  logic             dv_neg;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   a_sub;

  always_comb begin
    state_d = state_q;
    dd_d    = dd_q;
    dv_d    = dv_q;
    sm_d    = sm_q;
    q_d     = q_q;
    m_d     = m_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    sgn    = SIGNED_EN && sm_q;
    dd_neg = sgn & dd_q[WIDTH-1];
    dv_neg = sgn & dv_q[WIDTH-1];
    a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_sub  = a_sh - {1'b0, m_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dd_d    = dividend;
          dv_d    = divisor;
          sm_d    = signed_mode;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (dv_q == '0) begin
          quo_d   = '1;
          rem_d   = dd_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          q_d     = dd_neg ? -dd_q : dd_q;
          m_d     = dv_neg ? -dv_q : dv_q;
          a_d     = '0;
          cnt_d   = CW'(WIDTH);
          negq_d  = dd_neg ^ dv_neg;
          negr_d  = dd_neg;
          state_d = ITER;
        end
      end
      ITER: begin
        // a_sub's top bit set means the trial subtraction went negative
        if (a_sub[WIDTH]) begin
          a_d = a_sh;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          a_d = a_sub;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        quo_d   = negq_q ? -q_q : q_q;
        rem_d   = negr_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dd_q    <= '0;
      dv_q    <= '0;
      sm_q    <= 1'b0;
      q_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dd_q    <= dd_d;
      dv_q    <= dv_d;
      sm_q    <= sm_d;
      q_q     <= q_d;
      m_q     <= m_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign done        = done_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_restoring_divider_n.sv
// Bench for restoring_divider_n: 8-bit signed-capable and 16-bit unsigned-only
// instances checked against an arithmetic model every cycle plus literal vectors.
module tb_restoring_divider_n;

  logic clk;
  logic rst8, start8, sm8;
  logic [7:0] dd8, dv8, q8, r8;
  logic ready8, done8, dbz8;
  logic rst16, start16, sm16;
  logic [15:0] dd16, dv16, q16, r16;
  logic ready16, done16, dbz16;

  int n_tot = 0;
  int n_pass = 0;

  restoring_divider_n #(.WIDTH(8), .SIGNED_EN(1'b1)) u_d8 (
    .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8),
    .dividend(dd8), .divisor(dv8), .quotient(q8), .remainder(r8),
    .ready(ready8), .done(done8), .div_by_zero(dbz8)
  );

  restoring_divider_n #(.WIDTH(16), .SIGNED_EN(1'b0)) u_d16 (
    .clk(clk), .rst(rst16), .start(start16), .signed_mode(sm16),
    .dividend(dd16), .divisor(dv16), .quotient(q16), .remainder(r16),
    .ready(ready16), .done(done16), .div_by_zero(dbz16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  function automatic logic [47:0] pk(input logic rdy, input logic dn,
                                     input logic z, input logic [15:0] q,
                                     input logic [15:0] r);
    return {13'b0, rdy, dn, z, q, r};
  endfunction

  // Reference result: plain integer division on sign-interpreted operands
  task automatic expect_res(input int w, input bit sgn,
                            input logic [15:0] dd, input logic [15:0] dv,
                            output logic [15:0] q, output logic [15:0] r,
                            output logic z);
    longint mask, a, b, sa, sb;
    mask = (longint'(1) << w) - 1;
    a = longint'(dd) & mask;
    b = longint'(dv) & mask;
    if (b == 0) begin
      q = 16'(mask);
      r = 16'(a);
      z = 1'b1;
    end else begin
      sa = (sgn && a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
      sb = (sgn && b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
      q = 16'((sa / sb) & mask);
      r = 16'((sa % sb) & mask);
      z = 1'b0;
    end
  endtask

  bit m8_on, b8, md8, mz8, pz8;
  logic [15:0] mq8, mr8, pq8, pr8;
  int t8, l8;
  bit m16_on, b16, md16, mz16, pz16;
  logic [15:0] mq16, mr16, pq16, pr16;
  int t16, l16;

  always @(posedge clk) begin
    if (rst8) begin
      m8_on = 1; b8 = 0; t8 = 0; md8 = 0; mz8 = 0;
      mq8 = 0; mr8 = 0;
    end else begin
      md8 = 0;
      if (b8) begin
        t8++;
        if (t8 == l8 - 1) begin
          md8 = 1; mq8 = pq8; mr8 = pr8; mz8 = pz8;
        end
        if (t8 == l8) b8 = 0;
      end else if (start8) begin
        expect_res(8, sm8, {8'h0, dd8}, {8'h0, dv8}, pq8, pr8, pz8);
        l8 = (dv8 == 0) ? 2 : 11;
        b8 = 1; t8 = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst16) begin
      m16_on = 1; b16 = 0; t16 = 0; md16 = 0; mz16 = 0;
      mq16 = 0; mr16 = 0;
    end else begin
      md16 = 0;
      if (b16) begin
        t16++;
        if (t16 == l16 - 1) begin
          md16 = 1; mq16 = pq16; mr16 = pr16; mz16 = pz16;
        end
        if (t16 == l16) b16 = 0;
      end else if (start16) begin
        expect_res(16, 1'b0, dd16, dv16, pq16, pr16, pz16);
        l16 = (dv16 == 0) ? 2 : 19;
        b16 = 1; t16 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m8_on)
      chk("cyc8", pk(ready8, done8, dbz8, {8'h0, q8}, {8'h0, r8}),
          pk(!b8, md8, mz8, mq8, mr8));
    if (m16_on)
      chk("cyc16", pk(ready16, done16, dbz16, q16, r16),
          pk(!b16, md16, mz16, mq16, mr16));
  end

  task automatic op(input bit w16, input bit sm, input logic [15:0] dd,
                    input logic [15:0] dv, input logic [15:0] eq,
                    input logic [15:0] er, input bit ez, input int el,
                    input string nm);
    int c;
    @(negedge clk);
    if (w16) begin
      sm16 = sm; dd16 = dd; dv16 = dv; start16 = 1;
    end else begin
      sm8 = sm; dd8 = dd[7:0]; dv8 = dv[7:0]; start8 = 1;
    end
    @(negedge clk);
    start8 = 0;
    start16 = 0;
    c = 1;
    while (!(w16 ? done16 : done8) && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_lat"}, 48'(c), 48'(el));
    if (w16)
      chk(nm, pk(1'b0, 1'b0, dbz16, q16, r16), pk(1'b0, 1'b0, ez, eq, er));
    else
      chk(nm, pk(1'b0, 1'b0, dbz8, {8'h0, q8}, {8'h0, r8}),
          pk(1'b0, 1'b0, ez, eq, er));
  endtask

  initial begin
    int c, nd;
    logic [15:0] xq, xr;
    logic xz;
    rst8 = 1; rst16 = 1; start8 = 0; start16 = 0;
    sm8 = 0; dd8 = 0; dv8 = 0; sm16 = 0; dd16 = 0; dv16 = 0;
    repeat (2) @(negedge clk);
    chk("rst8", pk(ready8, done8, dbz8, {8'h0, q8}, {8'h0, r8}),
        pk(1'b1, 1'b0, 1'b0, 16'h0, 16'h0));
    chk("rst16", pk(ready16, done16, dbz16, q16, r16),
        pk(1'b1, 1'b0, 1'b0, 16'h0, 16'h0));
    rst8 = 0;
    rst16 = 0;

    expect_res(8, 1'b1, 16'h00F9, 16'h0002, xq, xr, xz);
    chk("model_s", pk(1'b0, 1'b0, xz, xq, xr), pk(1'b0, 1'b0, 1'b0, 16'hFD, 16'hFF));
    expect_res(8, 1'b1, 16'h0080, 16'h00FF, xq, xr, xz);
    chk("model_min", pk(1'b0, 1'b0, xz, xq, xr), pk(1'b0, 1'b0, 1'b0, 16'h80, 16'h0));
    expect_res(8, 1'b0, 16'h000D, 16'h0000, xq, xr, xz);
    chk("model_dbz", pk(1'b0, 1'b0, xz, xq, xr), pk(1'b0, 1'b0, 1'b1, 16'hFF, 16'h0D));

    op(0, 0, 16'd200, 16'd7, 16'd28, 16'd4, 0, 11, "t1_u200_7");
    op(0, 1, 16'hF9, 16'h02, 16'hFD, 16'hFF, 0, 11, "t2_sm7_2");
    op(0, 1, 16'h07, 16'hFE, 16'hFD, 16'h01, 0, 11, "t2_s7_m2");
    op(0, 0, 16'd13, 16'd0, 16'hFF, 16'd13, 1, 2, "t3_dbz");
    op(0, 1, 16'h80, 16'hFF, 16'h80, 16'h00, 0, 11, "t4_smin_m1");
    op(0, 0, 16'h80, 16'hFF, 16'h00, 16'h80, 0, 11, "t4_u128_255");
    op(0, 1, 16'h80, 16'h00, 16'hFF, 16'h80, 1, 2, "s_dbz");
    op(0, 1, 16'h9C, 16'h07, 16'hF2, 16'hFE, 0, 11, "sm100_7");
    op(0, 1, 16'h80, 16'h80, 16'h01, 16'h00, 0, 11, "smin_min");
    op(0, 0, 16'hFF, 16'h01, 16'hFF, 16'h00, 0, 11, "u255_1");
    op(0, 0, 16'd5, 16'd9, 16'd0, 16'd5, 0, 11, "u5_9");
    op(1, 1, 16'hFFFF, 16'd255, 16'd257, 16'd0, 0, 19, "t6_w16");
    op(1, 1, 16'h8000, 16'd3, 16'h2AAA, 16'd2, 0, 19, "w16_nosign");
    op(1, 0, 16'd77, 16'd0, 16'hFFFF, 16'd77, 1, 2, "w16_dbz");

    @(negedge clk);
    sm8 = 0; dd8 = 200; dv8 = 7; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    sm8 = 1; dd8 = 8'h09; dv8 = 8'h03; start8 = 1;
    repeat (2) @(negedge clk);
    start8 = 0;
    c = 6;
    while (!done8 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("ign_lat", 48'(c), 48'd11);
    chk("ign_res", pk(1'b0, 1'b0, dbz8, {8'h0, q8}, {8'h0, r8}),
        pk(1'b0, 1'b0, 1'b0, 16'd28, 16'd4));

    @(negedge clk);
    sm8 = 0; dd8 = 200; dv8 = 7; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    rst8 = 1;
    @(negedge clk);
    chk("rst_iter", pk(ready8, done8, dbz8, {8'h0, q8}, {8'h0, r8}),
        pk(1'b1, 1'b0, 1'b0, 16'h0, 16'h0));
    rst8 = 0;

    @(negedge clk);
    sm8 = 0; dd8 = 10; dv8 = 3; start8 = 1;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done8) nd++;
    end
    start8 = 0;
    chk("held_cnt", 48'(nd), 48'd2);
    repeat (20) @(negedge clk);
    chk("held_res", pk(1'b0, 1'b0, dbz8, {8'h0, q8}, {8'h0, r8}),
        pk(1'b0, 1'b0, 1'b0, 16'd3, 16'd1));

    rst8 = 1; start8 = 1; dd8 = 50; dv8 = 5;
    @(negedge clk);
    chk("rst_prio", pk(ready8, done8, dbz8, {8'h0, q8}, {8'h0, r8}),
        pk(1'b1, 1'b0, 1'b0, 16'h0, 16'h0));
    rst8 = 0;
    start8 = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
